// File: rtl/user_req_arbiter_pkg.sv
// Shared types and defaults for the two-port user request arbiter.
package user_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        WR = 1'b0,
        RD = 1'b1
    } dir_e;

    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/user_req_arbiter_rr_arb2.sv
// Two-way round-robin picker: with both pending, the one not granted last wins.
module rr_arb2 (
    input  logic [1:0] pending,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |pending;
        grant_idx   = 1'b0;
        if (pending == 2'b11) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = pending[1];
        end
    end

endmodule

// File: rtl/user_req_arbiter.sv
// Shares the master's U_* request port between two requesters, one transaction
// at a time, with a WAIT-state timeout. Valid/ready: a request is a level held until rN_ack.
module user_req_arbiter
    import user_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CW      = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_wreq,
    input  logic        r0_rreq,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [3:0]  r0_strb,
    input  logic [3:0]  r0_blen,
    output logic        r0_ack,
    output logic        r0_done,
    output logic        r0_err,
    output logic        r0_rvld,
    input  logic        r1_wreq,
    input  logic        r1_rreq,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [3:0]  r1_strb,
    input  logic [3:0]  r1_blen,
    output logic        r1_ack,
    output logic        r1_done,
    output logic        r1_err,
    output logic        r1_rvld,
    output logic [31:0] rdata,
    output logic        U_WVALID,
    output logic        U_RVALID,
    output logic [31:0] U_AWADDR,
    output logic [31:0] U_WDATA,
    output logic [31:0] U_ARADDR,
    output logic [3:0]  U_STRB,
    output logic [3:0]  U_BLEN,
    input  logic [31:0] U_RDATA,
    input  logic        U_RBEAT,
    input  logic        U_WDONE,
    input  logic        U_RDONE,
    output state_e      dbg_state
);

    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          gnt_q, gnt_d;
    dir_e          dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [1:0]    rvld_q, rvld_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          wvalid_q, wvalid_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   awaddr_q, awaddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [3:0]    strb_q, strb_d;
    logic [3:0]    blen_q, blen_d;

    logic [1:0]    pending;
    logic          grant_valid;
    logic          grant_idx;
    logic          sel_wreq;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_strb;
    logic [3:0]    sel_blen;
    logic          complete;

    assign pending = {r1_wreq | r1_rreq, r0_wreq | r0_rreq};

    rr_arb2 u_rr_arb2 (
        .pending     (pending),
        .last_grant  (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        sel_wreq  = grant_idx ? r1_wreq  : r0_wreq;
        sel_addr  = grant_idx ? r1_addr  : r0_addr;
        sel_wdata = grant_idx ? r1_wdata : r0_wdata;
        sel_strb  = grant_idx ? r1_strb  : r0_strb;
        sel_blen  = grant_idx ? r1_blen  : r0_blen;
        complete  = (dir_q == WR) ? U_WDONE : U_RDONE;
    end

    // U_* strobes and operands are loaded on the IDLE->ISSUE edge so they are
    // registered yet visible during the ISSUE cycle.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        ack_d    = 2'b00;
        done_d   = 2'b00;
        err_d    = 2'b00;
        rvld_d   = 2'b00;
        rdata_d  = rdata_q;
        wvalid_d = 1'b0;
        rvalid_d = 1'b0;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        araddr_d = araddr_q;
        strb_d   = strb_q;
        blen_d   = blen_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    gnt_d            = grant_idx;
                    last_d           = grant_idx;
                    ack_d[grant_idx] = 1'b1;
                    state_d          = ISSUE;
                    if (sel_wreq) begin
                        dir_d    = WR;
                        wvalid_d = 1'b1;
                        awaddr_d = sel_addr;
                        wdata_d  = sel_wdata;
                        strb_d   = sel_strb;
                    end else begin
                        dir_d    = RD;
                        rvalid_d = 1'b1;
                        araddr_d = sel_addr;
                        blen_d   = sel_blen;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (dir_q == RD && U_RBEAT) begin
                    rdata_d       = U_RDATA;
                    rvld_d[gnt_q] = 1'b1;
                end
                if (complete) begin
                    done_d[gnt_q] = 1'b1;
                    state_d       = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    err_d[gnt_q] = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            dir_q    <= WR;
            cnt_q    <= '0;
            ack_q    <= 2'b00;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            rvld_q   <= 2'b00;
            rdata_q  <= '0;
            wvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            araddr_q <= '0;
            strb_q   <= '0;
            blen_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rvld_q   <= rvld_d;
            rdata_q  <= rdata_d;
            wvalid_q <= wvalid_d;
            rvalid_q <= rvalid_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            araddr_q <= araddr_d;
            strb_q   <= strb_d;
            blen_q   <= blen_d;
        end
    end

    assign {r1_ack,  r0_ack}  = ack_q;
    assign {r1_done, r0_done} = done_q;
    assign {r1_err,  r0_err}  = err_q;
    assign {r1_rvld, r0_rvld} = rvld_q;
    assign rdata     = rdata_q;
    assign U_WVALID  = wvalid_q;
    assign U_RVALID  = rvalid_q;
    assign U_AWADDR  = awaddr_q;
    assign U_WDATA   = wdata_q;
    assign U_ARADDR  = araddr_q;
    assign U_STRB    = strb_q;
    assign U_BLEN    = blen_q;
    assign dbg_state = state_q;

endmodule

// File: doc/user_req_arbiter.md
# user_req_arbiter

Two-port arbiter that shares the single user-side request interface of the AXI master (U_* signals) between two independent requesters, e.g. a switch-driven test client and a second traffic source. It grants one transaction at a time in round-robin order, drives the U_* write/read strobes for exactly one cycle per transaction, and waits for the master's completion before the next grant. Read beats are returned to the granted requester. A timeout guards against a hung master.

## Interface
- TIMEOUT, 1024: WAIT-state cycle limit before a transaction is abandoned; minimum 2.
- CW, 11: timeout counter width; must satisfy 2^CW >= TIMEOUT.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs on the next rising edge.
- rN_wreq, rN_rreq (N=0,1)  in  1  level request, held until rN_ack.
- rN_addr  in  32  write address or read address.
- rN_wdata  in  32  write data.
- rN_strb  in  4  write byte strobes.
- rN_blen  in  4  read burst length, passed through unchanged.
- rN_ack  out  1  one-cycle pulse: request captured and issued.
- rN_done  out  1  one-cycle pulse: transaction completed.
- rN_err  out  1  one-cycle pulse: transaction timed out.
- rN_rvld  out  1  one-cycle pulse per forwarded read beat.
- rdata  out  32  last forwarded read beat, shared by both requesters.
- U_WVALID, U_RVALID  out  1  one-cycle issue strobes to master.
- U_AWADDR, U_WDATA, U_ARADDR  out  32; U_STRB, U_BLEN  out  4.
- U_RDATA  in  32; U_RBEAT  in  1 (read beat valid); U_WDONE, U_RDONE  in  1 (completion pulses).

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: requester N is pending if rN_wreq|rN_rreq. One pending -> grant it. Both pending -> grant the one not granted last (last_grant resets to 1, so r0 wins first). Within a requester, wreq beats rreq. Capture direction, grant and the operands; go to ISSUE.
- ISSUE (1 cycle): U_WVALID or U_RVALID = 1, rN_ack = 1 for the granted N; write loads U_AWADDR/U_WDATA/U_STRB, read loads U_ARADDR/U_BLEN. Clear timeout counter; go to WAIT.
- WAIT write: U_WDONE -> rN_done pulse, IDLE. U_RDONE and U_RBEAT ignored.
- WAIT read: each U_RBEAT -> rdata <= U_RDATA and rN_rvld pulse. U_RDONE -> rN_done pulse, IDLE. Beat and RDONE in the same cycle: beat forwarded and done both pulse. U_WDONE ignored. Beats are not counted; completion is by U_RDONE only.
- Timeout: counter increments each WAIT cycle; on reaching TIMEOUT-1 with no completion -> rN_err pulse, IDLE. Completion on that same cycle wins (done, no err).
- last_grant updated when entering ISSUE.
- U_WDONE/U_RDONE/U_RBEAT outside WAIT are ignored.
- Reset mid-transaction: return to IDLE, no done/err, all outputs 0; master-side completion after reset is ignored.
- Requester must drop its request after rN_ack. A request still held on return to IDLE is treated as a new request.

## Timing
- Reset value of every output is 0: strobes, ack/done/err/rvld pulses, U_AWADDR, U_WDATA, U_STRB, U_ARADDR, U_BLEN, rdata. State = IDLE, last_grant = 1, counter = 0.
- All outputs are registered.
- Request sampled in IDLE at edge t -> U_*VALID and rN_ack high during cycle t+1.
- Completion sampled at edge u -> rN_done high during cycle u+1, state IDLE. A new grant is possible at edge u+1, so the next ISSUE is in cycle u+2. Minimum period is 3 cycles per transaction.
- U_RBEAT at edge v -> rdata/rN_rvld valid during cycle v+1.
- U_AWADDR/U_WDATA/U_STRB/U_ARADDR/U_BLEN hold their values until the next ISSUE of the same direction.

## Structure
- Package user_arb_pkg: state typedef (IDLE/ISSUE/WAIT), direction typedef (WR/RD), default TIMEOUT constant.
- Sub-module rr_arb2: combinational two-way round-robin picker. Inputs are the pending vector and last_grant; outputs are grant_valid and grant_idx. All other logic lives in the top.

## Test plan
- r0_wreq with addr 0x0, wdata 0x1234, strb 0xF; U_WDONE 5 cycles after U_WVALID -> r0_ack on the cycle after the request, U_WDATA=0x1234, r0_done one cycle after U_WDONE.
- r0 and r1 both assert rreq in the same cycle, repeated 4 times -> grants alternate r0,r1,r0,r1,... with U_ARADDR matching each requester's address.
- r1 read with blen 0xF; 4 U_RBEAT carrying 0xA..0xD, last beat coincident with U_RDONE -> 4 r1_rvld pulses with rdata A..D, and r1_done in the same cycle as the last r1_rvld.
- r0 holds wreq and rreq together -> write is issued first; read is issued after r0_done when rreq is still held.
- TIMEOUT=8, no completion -> r0_err exactly 8 WAIT cycles after entry; a late U_WDONE is ignored; next request proceeds normally.
- reset asserted during WAIT, then U_RDONE -> all outputs 0, no done pulse, IDLE; first grant after reset goes to r0.
